// File: rtl/ac_vlc_pkg.sv
// Shared types and width helpers for the AC codeword packer.
// No logic and no latency.
// No backpressure behaviour.
package ac_vlc_pkg;

  // Bits needed to hold a run or level length of 0..code_w.
  function automatic int calc_len_w(input int code_w);
    return $clog2(code_w + 1);
  endfunction

  // Bits needed to hold an output size of 0..out_w.
  function automatic int calc_sz_w(input int out_w);
    return $clog2(out_w + 1);
  endfunction

  localparam int DEF_CODE_W = 32;
  localparam int DEF_OUT_W  = 64;

  // FIFO entry layout for the default build. The top level declares the
  // same {code, size} layout sized by its own OUT_W.
  typedef struct packed {
    logic [DEF_OUT_W-1:0]             code;
    logic [calc_sz_w(DEF_OUT_W)-1:0]  size;
  } ac_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } pack_state_t;

endpackage

// File: rtl/ac_codeword_packer_if.sv
// Handshake and data bundle between the VLC encoders, packer and writer.
// No logic and no latency.
// Backpressure is carried by in_ready and out_ready.
interface ac_codeword_packer_if #(
  parameter int CODE_W = 32,
  parameter int OUT_W  = 64
) ();
  localparam int LEN_W = ac_vlc_pkg::calc_len_w(CODE_W);
  localparam int SZ_W  = ac_vlc_pkg::calc_sz_w(OUT_W);

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] run_sum;
  logic [LEN_W-1:0]  run_length;
  logic [CODE_W-1:0] level_sum;
  logic [LEN_W-1:0]  level_length;
  logic              flush_req;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  val;
  logic [SZ_W-1:0]   size_of_bit;
  logic              flush_bit;
  logic              overflow_err;

  // Producer/consumer side that drives codewords in and takes beats out.
  modport master (
    output in_valid, run_sum, run_length, level_sum, level_length,
           flush_req, out_ready,
    input  in_ready, out_valid, val, size_of_bit, flush_bit, overflow_err
  );

  // The packer itself.
  modport slave (
    input  in_valid, run_sum, run_length, level_sum, level_length,
           flush_req, out_ready,
    output in_ready, out_valid, val, size_of_bit, flush_bit, overflow_err
  );
endinterface

// File: rtl/ac_code_fifo.sv
// Synchronous FIFO with one push and a pop of one or two entries per cycle.
// Written entry is visible at head0 the cycle after the push edge.
// Caller must not push when full nor pop more entries than count.
module ac_code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop1,
  input  logic                   pop2,
  output logic [WIDTH-1:0]       head0,
  output logic [WIDTH-1:0]       head1,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr1;
  logic [CNT_W-1:0] pop_cnt;
  logic [CNT_W-1:0] count_nxt;

  // Pop amount and next occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    pop_cnt = '0;
    if (pop2) begin
      pop_cnt = CNT_W'(2);
    end else if (pop1) begin
      pop_cnt = CNT_W'(1);
    end
    count_nxt = count + CNT_W'(push) - pop_cnt;
    rd_ptr1   = rd_ptr + 1'b1;
    head0     = mem[rd_ptr];
    head1     = mem[rd_ptr1];
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers plus registered count and full flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
      count  <= count_nxt;
      full   <= (count_nxt == CNT_W'(DEPTH));
    end
  end
endmodule

// File: rtl/ac_codeword_packer.sv
// Forms run/level codewords, buffers them, merges pairs into one beat, flushes.
// Latency: accepted codeword reaches out_valid one edge later at the earliest.
// in_ready drops when the FIFO is full or while draining/flushing; beats hold under !out_ready.
module ac_codeword_packer
  import ac_vlc_pkg::*;
#(
  parameter int CODE_W  = 32,
  parameter int OUT_W   = 64,
  parameter int DEPTH   = 4,
  parameter int PAIR_EN = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  ac_codeword_packer_if.slave  bus
);
  localparam int LEN_W = calc_len_w(CODE_W);
  localparam int SZ_W  = calc_sz_w(OUT_W);
  localparam int SUM_W = LEN_W + 1;

  typedef struct packed {
    logic [OUT_W-1:0] code;
    logic [SZ_W-1:0]  size;
  } entry_t;
  localparam int ENT_W = $bits(entry_t);

  // Ones below len, zeros from len upward; lengths beyond CODE_W keep every bit.
  function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [CODE_W-1:0] m;
    for (int i = 0; i < CODE_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  pack_state_t state;
  pack_state_t state_nxt;

  logic [CODE_W-1:0]     run_m;
  logic [CODE_W-1:0]     lvl_m;
  logic [SUM_W-1:0]      size_full;
  logic                  len_err;
  entry_t                push_ent;
  entry_t                head0;
  entry_t                head1;
  logic [$clog2(DEPTH):0] count;
  logic                  full;
  logic                  in_rdy;
  logic                  push;
  logic                  reg_free;
  logic                  do_merge;
  logic                  pop1;
  logic                  pop2;
  logic [SZ_W:0]         pair_size;
  logic [OUT_W-1:0]      merged_code;
  logic                  out_vld_r;
  logic [OUT_W-1:0]      val_r;
  logic [SZ_W-1:0]       size_r;
  logic                  err_r;

  // Codeword former: mask each field to its length, concatenate, clamp on error.
  always_comb begin
    run_m     = bus.run_sum & len_mask(bus.run_length);
    lvl_m     = bus.level_sum & len_mask(bus.level_length);
    size_full = SUM_W'(bus.run_length) + SUM_W'(bus.level_length);
    len_err   = (int'(bus.run_length) > CODE_W) ||
                (int'(bus.level_length) > CODE_W) ||
                (int'(size_full) > OUT_W);
    push_ent.code = (OUT_W'(run_m) << bus.level_length) | OUT_W'(lvl_m);
    push_ent.size = (int'(size_full) > OUT_W) ? SZ_W'(OUT_W) : SZ_W'(size_full);
    in_rdy = reset_n && !full && (state == RUN);
    push   = bus.in_valid && in_rdy;
  end

  ac_code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (push_ent),
    .pop1     (pop1),
    .pop2     (pop2),
    .head0    (head0),
    .head1    (head1),
    .count    (count),
    .full     (full)
  );

  // Pair-merge mux: merge whenever two entries are already present and fit.
  always_comb begin
    reg_free    = !out_vld_r || bus.out_ready;
    pair_size   = (SZ_W+1)'(head0.size) + (SZ_W+1)'(head1.size);
    do_merge    = (PAIR_EN != 0) && (int'(count) >= 2) && (int'(pair_size) <= OUT_W);
    pop2        = reg_free && do_merge;
    pop1        = reg_free && !do_merge && (count != '0);
    merged_code = (head0.code << head1.size) | head1.code;
  end

  // Output register: reload from the FIFO head whenever empty or being consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_r <= 1'b0;
      val_r     <= '0;
      size_r    <= '0;
    end else if (reg_free) begin
      if (pop2) begin
        out_vld_r <= 1'b1;
        val_r     <= merged_code;
        size_r    <= pair_size[SZ_W-1:0];
      end else if (pop1) begin
        out_vld_r <= 1'b1;
        val_r     <= head0.code;
        size_r    <= head0.size;
      end else begin
        out_vld_r <= 1'b0;
      end
    end
  end

  // Sticky length error, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (push && len_err) begin
      err_r <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; the flush beat overrides the (empty) output register.
  always_comb begin
    state_nxt        = state;
    bus.in_ready     = in_rdy;
    bus.out_valid    = out_vld_r;
    bus.val          = val_r;
    bus.size_of_bit  = size_r;
    bus.flush_bit    = 1'b0;
    bus.overflow_err = err_r;
    case (state)
      RUN: begin
        if (bus.flush_req) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((count == '0) && reg_free) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        bus.out_valid   = 1'b1;
        bus.flush_bit   = 1'b1;
        bus.val         = '0;
        bus.size_of_bit = '0;
        if (bus.out_ready) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end
endmodule
